// File: rtl/image_upscaler_pkg.sv
// Shared widths, default source geometry and FSM encoding for the image upscaler.
// Pure declarations: no logic, no latency.
// No flow control lives here; consumers define their own handshakes.
package image_upscaler_pkg;

    localparam int ADDR_W        = 19;
    localparam int PIX_W         = 8;
    localparam int SRC_W_DEFAULT = 160;
    localparam int SRC_H_DEFAULT = 120;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/scale_axis_counter.sv
// One axis of the upscaler: destination index, matching source index and last-index wrap flag.
// Outputs are registered indices; wrap is combinational from dst_idx (same cycle).
// No backpressure: advances exactly on cycles where advance is high.
//
// Ports: clk, reset (sync, active high), clear (restart at 0), advance (step one destination pixel),
//        dst_idx / src_idx (current indices), wrap (dst_idx is the last index of the axis).
module scale_axis_counter
    import image_upscaler_pkg::*;
#(
    parameter int SCALE   = 2,
    parameter int SRC_LEN = SRC_W_DEFAULT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              advance,
    output logic [ADDR_W-1:0] dst_idx,
    output logic [ADDR_W-1:0] src_idx,
    output logic              wrap
);

    localparam int DST_LEN = SRC_LEN * SCALE;

    // Replication phase within one source pixel; SCALE <= 4 fits in two bits.
    logic [1:0] phase;

    assign wrap = (dst_idx == ADDR_W'(DST_LEN - 1));

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            dst_idx <= '0;
            src_idx <= '0;
            phase   <= '0;
        end else if (advance) begin
            if (wrap) begin
                // End of axis: all three restart together so the next line/frame begins aligned.
                dst_idx <= '0;
                src_idx <= '0;
                phase   <= '0;
            end else begin
                dst_idx <= dst_idx + ADDR_W'(1);
                if (phase == 2'(SCALE - 1)) begin
                    phase   <= '0;
                    src_idx <= src_idx + ADDR_W'(1);
                end else begin
                    phase <= phase + 2'd1;
                end
            end
        end
    end

endmodule

// File: rtl/image_upscaler.sv
// Nearest-neighbour integer upscaler: reads a source image from ROM, writes a SCALE x enlarged copy to a framebuffer.
// Latency: first ROM address the cycle after start, first framebuffer write one cycle later (matches ROM read latency).
// No backpressure: one destination pixel per RUN cycle; start while busy is ignored.
//
// Ports: clk, reset (sync, active high), start (pulse, accepted in IDLE/DONE),
//        rom_addr/rom_data (1-cycle registered ROM), ram_wraddr/ram_data/ram_wren (framebuffer write),
//        busy (RUN or FLUSH), done (held until next accepted start or reset).
module image_upscaler
    import image_upscaler_pkg::*;
#(
    parameter int SRC_W = SRC_W_DEFAULT,
    parameter int SRC_H = SRC_H_DEFAULT,
    parameter int SCALE = 2              // legal range 1..4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [PIX_W-1:0]  rom_data,
    output logic [ADDR_W-1:0] ram_wraddr,
    output logic [PIX_W-1:0]  ram_data,
    output logic              ram_wren,
    output logic              busy,
    output logic              done
);

    localparam int                DST_W   = SRC_W * SCALE;
    localparam logic [ADDR_W-1:0] SRC_W_A = ADDR_W'(SRC_W);
    localparam logic [ADDR_W-1:0] DST_W_A = ADDR_W'(DST_W);

    state_t state, state_nxt;

    logic              start_ok;
    logic              issue;
    logic              last_pix;
    logic [ADDR_W-1:0] dx, dy, sx, sy;
    logic              x_wrap, y_wrap;

    // One-stage write pipeline aligning the destination address with rom_data.
    logic              wr_vld;
    logic [ADDR_W-1:0] wr_addr;

    assign start_ok = start && ((state == ST_IDLE) || (state == ST_DONE));
    assign issue    = (state == ST_RUN);
    assign last_pix = issue && x_wrap && y_wrap;

    scale_axis_counter #(
        .SCALE   (SCALE),
        .SRC_LEN (SRC_W)
    ) u_x_axis (
        .clk     (clk),
        .reset   (reset),
        .clear   (start_ok),
        .advance (issue),
        .dst_idx (dx),
        .src_idx (sx),
        .wrap    (x_wrap)
    );

    scale_axis_counter #(
        .SCALE   (SCALE),
        .SRC_LEN (SRC_H)
    ) u_y_axis (
        .clk     (clk),
        .reset   (reset),
        .clear   (start_ok),
        .advance (issue && x_wrap),
        .dst_idx (dy),
        .src_idx (sy),
        .wrap    (y_wrap)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (start) state_nxt = ST_RUN;
            ST_RUN:   if (last_pix) state_nxt = ST_FLUSH;
            // The final pixel's ROM data returns during FLUSH.
            ST_FLUSH: state_nxt = ST_DONE;
            ST_DONE:  if (start) state_nxt = ST_RUN;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    assign busy = (state == ST_RUN) || (state == ST_FLUSH);
    assign done = (state == ST_DONE);

    assign rom_addr = issue ? (sy * SRC_W_A + sx) : '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_vld  <= 1'b0;
            wr_addr <= '0;
        end else begin
            wr_vld  <= issue;
            wr_addr <= issue ? (dy * DST_W_A + dx) : '0;
        end
    end

    assign ram_wren   = wr_vld;
    assign ram_wraddr = wr_addr;
    // Gate with the valid bit so a stale ROM word never shows on the bus outside a write.
    assign ram_data   = wr_vld ? rom_data : '0;

endmodule

// File: tb/tb_image_upscaler.sv
module tb_image_upscaler;

    localparam int SW = 20;
    localparam int SH = 15;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        start_a    [3];
    logic [18:0] rom_addr_a [3];
    logic [7:0]  rom_data_a [3];
    logic [18:0] wraddr_a   [3];
    logic [7:0]  wdata_a    [3];
    logic        wren_a     [3];
    logic        busy_a     [3];
    logic        done_a     [3];

    int tests = 0;
    int fails = 0;

    // Instance 0: SCALE 2, instance 1: SCALE 1, instance 2: SCALE 4; all on a 20x15 source.
    image_upscaler #(.SRC_W(SW), .SRC_H(SH), .SCALE(2)) u_s2 (
        .clk(clk), .reset(reset), .start(start_a[0]), .rom_addr(rom_addr_a[0]), .rom_data(rom_data_a[0]),
        .ram_wraddr(wraddr_a[0]), .ram_data(wdata_a[0]), .ram_wren(wren_a[0]), .busy(busy_a[0]), .done(done_a[0]));
    image_upscaler #(.SRC_W(SW), .SRC_H(SH), .SCALE(1)) u_s1 (
        .clk(clk), .reset(reset), .start(start_a[1]), .rom_addr(rom_addr_a[1]), .rom_data(rom_data_a[1]),
        .ram_wraddr(wraddr_a[1]), .ram_data(wdata_a[1]), .ram_wren(wren_a[1]), .busy(busy_a[1]), .done(done_a[1]));
    image_upscaler #(.SRC_W(SW), .SRC_H(SH), .SCALE(4)) u_s4 (
        .clk(clk), .reset(reset), .start(start_a[2]), .rom_addr(rom_addr_a[2]), .rom_data(rom_data_a[2]),
        .ram_wraddr(wraddr_a[2]), .ram_data(wdata_a[2]), .ram_wren(wren_a[2]), .busy(busy_a[2]), .done(done_a[2]));

    // ROM model: registered read, pixel = low byte of the address.
    always @(posedge clk) begin
        for (int i = 0; i < 3; i++) rom_data_a[i] <= rom_addr_a[i][7:0];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic check_idle(input int d, input string tag);
        check({tag, "_wren"},   32'(wren_a[d]),     32'd0);
        check({tag, "_busy"},   32'(busy_a[d]),     32'd0);
        check({tag, "_done"},   32'(done_a[d]),     32'd0);
        check({tag, "_romadr"}, 32'(rom_addr_a[d]), 32'd0);
        check({tag, "_wradr"},  32'(wraddr_a[d]),   32'd0);
        check({tag, "_wdata"},  32'(wdata_a[d]),    32'd0);
    endtask

    // Full pass on instance d; inputs driven and outputs sampled on the falling edge.
    task automatic run_pass(input int d, input int sc, input bit spam, input string tag);
        int dw, dh, total, n, cyc, bad_addr, bad_data, bad_track, dx, dy, src;
        int last_addr, last_data, px0, px1, pxw, pxw1, px2;
        logic [18:0] prev_rom;
        dw = SW * sc; dh = SH * sc; total = dw * dh;
        n = 0; bad_addr = 0; bad_data = 0; bad_track = 0;
        last_addr = -1; last_data = -1; px0 = -1; px1 = -1; pxw = -1; pxw1 = -1; px2 = -1;
        start_a[d] = 1'b1;
        @(negedge clk);                 // edge k sampled start; this is cycle k+1
        start_a[d] = 1'b0;
        cyc = 1;
        check({tag, "_k1_busy"},   32'(busy_a[d]),     32'd1);
        check({tag, "_k1_wren"},   32'(wren_a[d]),     32'd0);
        check({tag, "_k1_romadr"}, 32'(rom_addr_a[d]), 32'd0);
        prev_rom = rom_addr_a[d];
        while (done_a[d] !== 1'b1 && cyc < total + 20) begin
            start_a[d] = spam && (busy_a[d] === 1'b1) && (cyc % 5 == 0);
            @(negedge clk);
            cyc++;
            if (wren_a[d] === 1'b1) begin
                dx = n % dw;
                dy = n / dw;
                src = (dy / sc) * SW + dx / sc;
                if (wraddr_a[d] !== 19'(n)) bad_addr++;
                if (wdata_a[d] !== 8'(src)) bad_data++;
                if (wraddr_a[d] !== prev_rom && sc == 1) bad_track++;
                if (wraddr_a[d] == 19'(0))      px0  = int'(wdata_a[d]);
                if (wraddr_a[d] == 19'(1))      px1  = int'(wdata_a[d]);
                if (wraddr_a[d] == 19'(2))      px2  = int'(wdata_a[d]);
                if (wraddr_a[d] == 19'(dw))     pxw  = int'(wdata_a[d]);
                if (wraddr_a[d] == 19'(dw + 1)) pxw1 = int'(wdata_a[d]);
                last_addr = int'(wraddr_a[d]);
                last_data = int'(wdata_a[d]);
                n++;
            end
            prev_rom = rom_addr_a[d];
        end
        start_a[d] = 1'b0;
        check({tag, "_writes"},    32'(n),         32'(total));
        check({tag, "_bad_addr"},  32'(bad_addr),  32'd0);
        check({tag, "_bad_data"},  32'(bad_data),  32'd0);
        check({tag, "_done_cyc"},  32'(cyc),       32'(total + 2));
        check({tag, "_done"},      32'(done_a[d]), 32'd1);
        check({tag, "_busy_end"},  32'(busy_a[d]), 32'd0);
        check({tag, "_last_addr"}, 32'(last_addr), 32'(total - 1));
        check({tag, "_last_data"}, 32'(last_data), 32'((SW * SH - 1) % 256));
        if (sc == 1) check({tag, "_track"}, 32'(bad_track), 32'd0);
        if (sc == 2) begin
            check({tag, "_px_a0"},    32'(px0),  32'd0);
            check({tag, "_px_a1"},    32'(px1),  32'd0);
            check({tag, "_px_aw"},    32'(pxw),  32'd0);
            check({tag, "_px_aw1"},   32'(pxw1), 32'd0);
            check({tag, "_px_a2"},    32'(px2),  32'd1);
        end
    endtask

    initial begin
        int n, cyc, wr_seen;
        reset = 1'b1;
        for (int i = 0; i < 3; i++) start_a[i] = 1'b0;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 3; i++) check_idle(i, $sformatf("rst%0d", i));
        reset = 1'b0;
        repeat (2) @(negedge clk);
        check_idle(0, "idle");

        // First pass with start pulsed while busy: must not restart.
        run_pass(0, 2, 1'b1, "s2a");
        repeat (3) @(negedge clk);
        check("done_held", 32'(done_a[0]), 32'd1);
        check("done_nowr", 32'(wren_a[0]), 32'd0);
        // Start from DONE: a second identical pass.
        run_pass(0, 2, 1'b0, "s2b");

        run_pass(1, 1, 1'b0, "s1");
        run_pass(2, 4, 1'b0, "s4");

        // Abort mid-pass at the 1000th write.
        start_a[0] = 1'b1;
        @(negedge clk);
        start_a[0] = 1'b0;
        n = 0; cyc = 0;
        while (n < 1000 && cyc < 2000) begin
            @(negedge clk);
            cyc++;
            if (wren_a[0] === 1'b1) n++;
        end
        check("abort_reached", 32'(n), 32'd1000);
        reset = 1'b1;
        @(negedge clk);
        check_idle(0, "abort");
        reset = 1'b0;
        @(negedge clk);
        check_idle(0, "abort_post");
        run_pass(0, 2, 1'b0, "s2c");

        // Reset and start together: reset wins.
        start_a[0] = 1'b1;
        reset = 1'b1;
        @(negedge clk);
        start_a[0] = 1'b0;
        reset = 1'b0;
        check_idle(0, "rst_start");
        wr_seen = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (wren_a[0] === 1'b1 || busy_a[0] === 1'b1) wr_seen++;
        end
        check("rst_start_quiet", 32'(wr_seen), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/image_upscaler.md
IMAGE_UPSCALER -- requirements
Module: image_upscaler

Interface
REQ-001 Parameter SRC_W, default 160, source image width in pixels.
REQ-002 Parameter SRC_H, default 120, source image height in pixels.
REQ-003 Parameter SCALE, default 2, integer replication factor; legal range 1..4.
REQ-004 clk  in  1  single clock for all logic (pixel clock domain of the framebuffer).
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 start  in  1  one-cycle request to begin an upscale pass; sampled only in IDLE or DONE.
REQ-007 rom_addr  out  19  source ROM read address; the ROM has 1-cycle registered-read latency.
REQ-008 rom_data  in  8  source pixel, valid the cycle after rom_addr was presented.
REQ-009 ram_wraddr  out  19  framebuffer write address.
REQ-010 ram_data  out  8  framebuffer write pixel.
REQ-011 ram_wren  out  1  framebuffer write enable; one pixel per asserted cycle.
REQ-012 busy  out  1  high in RUN and FLUSH.
REQ-013 done  out  1  high in DONE; held until the next accepted start or reset.

Function
REQ-014 FSM states IDLE, RUN, FLUSH, DONE; IDLE->RUN and DONE->RUN on start=1; RUN->FLUSH after the last destination pixel is issued; FLUSH->DONE unconditionally after one cycle.
REQ-015 Destination frame is DST_W=SRC_W*SCALE by DST_H=SRC_H*SCALE, raster order, one destination pixel issued per RUN cycle, no stalls.
REQ-016 Destination counters dx (0..DST_W-1) and dy (0..DST_H-1); dx wraps to 0 and dy increments at dx=DST_W-1.
REQ-017 Source coordinates sx=floor(dx/SCALE), sy=floor(dy/SCALE), maintained by sub-counters (no divider); rom_addr = sy*SRC_W + sx, driven combinationally from counters in RUN, 0 otherwise.
REQ-018 Write address for an issued pixel = dy*DST_W + dx; delayed one cycle alongside a valid bit so ram_wraddr/ram_data/ram_wren align with rom_data.
REQ-019 ram_data = rom_data whenever ram_wren=1; no modification of pixel value.
REQ-020 Latency: start high at edge k -> first rom_addr in cycle k+1 -> first ram_wren (addr 0) in cycle k+2; last write in FLUSH; done rises one cycle later.
REQ-021 Pass length: exactly DST_W*DST_H writes, each destination address written once, in ascending order.
REQ-022 start while busy is ignored; start in DONE restarts with counters cleared.
REQ-023 All address arithmetic is 19-bit unsigned; DST_W*DST_H <= 307200 for all legal SCALE, no overflow.
REQ-024 SCALE=1 is a plain copy: ram_wraddr equals the rom_addr issued one cycle earlier.

Reset
REQ-025 reset forces state IDLE, counters 0, pipeline valid 0, and in the following cycle rom_addr=0, ram_wraddr=0, ram_data=0, ram_wren=0, busy=0, done=0.
REQ-026 reset mid-pass aborts immediately; no ram_wren in the cycle after reset is sampled; a later start performs a full pass from address 0.
REQ-027 reset has priority over start in the same cycle.

Structure
REQ-028 A shared package holds ADDR_W=19, PIX_W=8, default SRC_W/SRC_H, and the FSM state encoding.
REQ-029 One sub-module, scale_axis_counter, instantiated twice (x, y): outputs destination index, source index and wrap flag for one axis given SCALE and source length.

Verification
REQ-030 Reset then start, SCALE=2, ROM model returns pixel = addr[7:0] -> 76800 writes; write at ram_wraddr=0,1,320,321 all carry source pixel 0; ram_wraddr=2 carries pixel 1; done at cycle k+76802.
REQ-031 SCALE=1 -> 19200 writes, ram_wraddr(n)=n, ram_data(n)=n[7:0], ram_wraddr tracking rom_addr by exactly one cycle.
REQ-032 SCALE=4 -> 307200 writes; last write ram_wraddr=307199 carries source addr 19199.
REQ-033 start pulsed repeatedly during busy -> no restart, write count unchanged; start in DONE -> second identical pass.
REQ-034 reset asserted at write 1000 -> ram_wren=0 the following cycle, busy=0, done=0; subsequent start gives full pass from addr 0.
REQ-035 reset and start high in the same cycle -> state IDLE, no writes.
